id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Instruction-decode stage and ID/EX pipeline register of the MIPS core.
- Drives the register-bank read addresses from the IF/ID instruction and decodes the main control signals.
- Captures register operands, sign-extended immediate, register indices and control into the ID/EX register.
- Detects load-use hazards against its own ID/EX contents: it stalls IF/ID and inserts a bubble into EX.

Parameters:
DATA_WIDTH, 32, width of register operands and immediate
PC_WIDTH, 32, width of the carried PC+4 value

Ports:
i_clock  input  1  single clock; all state updates on rising edge
i_reset  input  1  asynchronous reset, active-high
i_valid  input  1  IF/ID slot holds a real instruction
i_instruction  input  32  IF/ID instruction word
i_pc  input  PC_WIDTH  IF/ID PC+4
i_flush  input  1  branch/jump taken; squash instruction in ID
i_regA  input  DATA_WIDTH  register-bank read data for rs
i_regB  input  DATA_WIDTH  register-bank read data for rt
o_rf_rs  output  5  register-bank rs address = i_instruction[25:21] (combinational)
o_rf_rt  output  5  register-bank rt address = i_instruction[20:16] (combinational)
o_stall  output  1  combinational; hold PC and IF/ID this cycle
o_valid  output  1  ID/EX slot valid
o_regA, o_regB  output  DATA_WIDTH  latched operands
o_imm  output  DATA_WIDTH  latched sign-extended instruction[15:0]
o_rs, o_rt, o_rd  output  5 each  latched register indices
o_pc  output  PC_WIDTH  latched PC+4
o_regdst, o_alusrc, o_memread, o_memwrite, o_memtoreg, o_regwrite, o_branch  output  1 each  latched control
o_aluop  output  2  latched ALU op class
o_funct  output  6  latched instruction[5:0]
o_illegal  output  1  latched: valid instruction with unknown opcode
o_stall_count  output  16  only with STALL_COUNT_EN

Behaviour:
- Reset (async, immediate): every registered output is 0. ID/EX then holds a bubble.
- Decode (opcode = instr[31:26]); signals are regdst, alusrc, memread, memwrite, memtoreg, regwrite, branch, aluop:
  - 0x00 R-type: 1,0,0,0,0,1,0,10
  - 0x23 LW: 0,1,1,0,1,1,0,00
  - 0x2B SW: 0,1,0,1,0,0,0,00
  - 0x04 BEQ: 0,0,0,0,0,0,1,01
  - 0x08 ADDI: 0,1,0,0,0,1,0,00
  - Other opcodes: all control 0, illegal=1. The slot stays valid so a later exception unit can act on it.
- Immediate: o_imm = {{(DATA_WIDTH-16){instr[15]}}, instr[15:0]}.
- Load-use hazard (combinational):
  - Definition: hazard = i_valid & o_valid & o_memread & (o_rt != 0) & ((o_rt == instr rs) | (uses_rt & o_rt == instr rt)).
  - uses_rt = 1 for opcodes R-type, SW and BEQ only.
- Priority per rising edge:
  1. i_flush = 1: load a bubble (o_valid=0, all control 0, o_illegal=0, data/index fields 0). o_stall = 0.
  2. Otherwise, hazard = 1: o_stall = 1 and load a bubble. The stalled instruction re-presents next cycle. The bubble clears memread, so a stall always lasts exactly 1 cycle.
  3. Otherwise: capture all fields. o_valid = i_valid. If i_valid = 0, control is forced to 0 (bubble).
- Latency: 1 cycle from ID inputs to ID/EX outputs.
- The register bank must present i_regA/i_regB combinationally from o_rf_rs/o_rf_rt within the same cycle.
- Reset asserted mid-operation: outputs go to 0 immediately. A pending stall is cancelled (o_stall = 0 while in reset).
- $0: a load with rt = 0 never causes a stall.

Optional Feature:
STALL_COUNT_EN
- Defined: the o_stall_count port exists. It increments on every edge where o_stall = 1, saturates at 0xFFFF, and is reset to 0 by i_reset.
- Undefined: no port and no counter logic. Stall behaviour is unchanged.

Test Plan:
- Reset mid-run, instr 0x00622020 valid -> all outputs 0 immediately; o_valid=0, o_stall=0.
- ADDI 0x2005FFFF, i_pc=0x8 -> next edge: o_imm=0xFFFFFFFF, o_rt=5, o_alusrc=1, o_regwrite=1, o_aluop=00, o_pc=0x8; o_rf_rs=0, o_rf_rt=5 combinationally.
- LW 0x8C230004 then ADD 0x00622020 (rs=3) -> o_stall=1 for exactly one cycle with bubble in EX; ADD captured on the following edge (o_rd=4, o_regdst=1, o_aluop=10).
- LW $3 then ADD 0x00233020 (rt=3) -> 1-cycle stall. LW $3 then ADDI 0x2065FFFF (rs=3) -> stall. LW $3 then ADDI 0x2003FFFF (rt=3 only) -> no stall.
- LW $3 followed by ADD rs=3 with i_flush=1 on the same cycle -> o_stall=0, bubble loaded. Separately, LW 0x8C200004 (rt=0) then 0x00002020 -> no stall.
- Opcode 0x3F valid -> o_illegal=1, o_valid=1, all control 0. With STALL_COUNT_EN, 3 hazards -> o_stall_count=3.

Source files
------------

// File: rtl/id_ex_stage.sv
// Instruction decode and ID/EX pipeline register with load-use stall detection.
// Optional: define STALL_COUNT_EN to add a saturating o_stall_count port.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [31:0]           i_instruction,
  input  logic [PC_WIDTH-1:0]   i_pc,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_regA,
  input  logic [DATA_WIDTH-1:0] i_regB,
  output logic [4:0]            o_rf_rs,
  output logic [4:0]            o_rf_rt,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_regA,
  output logic [DATA_WIDTH-1:0] o_regB,
  output logic [DATA_WIDTH-1:0] o_imm,
  output logic [4:0]            o_rs,
  output logic [4:0]            o_rt,
  output logic [4:0]            o_rd,
  output logic [PC_WIDTH-1:0]   o_pc,
  output logic                  o_regdst,
  output logic                  o_alusrc,
  output logic                  o_memread,
  output logic                  o_memwrite,
  output logic                  o_memtoreg,
  output logic                  o_regwrite,
  output logic                  o_branch,
  output logic [1:0]            o_aluop,
  output logic [5:0]            o_funct,
  output logic                  o_illegal
`ifdef STALL_COUNT_EN
  ,
  output logic [15:0]           o_stall_count
`endif
);

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] rega;
    logic [DATA_WIDTH-1:0] regb;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [PC_WIDTH-1:0]   pc;
    ctrl_t                 ctrl;
    logic [5:0]            funct;
    logic                  illegal;
  } idex_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  ctrl_t      dec;
  logic       known, uses_rt, hazard;
  idex_t      q, nxt;

  assign opcode  = i_instruction[31:26];
  assign rs      = i_instruction[25:21];
  assign rt      = i_instruction[20:16];
  assign o_rf_rs = rs;
  assign o_rf_rt = rt;

  always_comb begin
    dec     = '0;
    known   = 1'b1;
    uses_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin dec = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10}; uses_rt = 1'b1; end
      OP_LW:    dec = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00};
      OP_SW:    begin dec = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00}; uses_rt = 1'b1; end
      OP_BEQ:   begin dec = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01}; uses_rt = 1'b1; end
      OP_ADDI:  dec = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      default:  known = 1'b0;
    endcase
  end

  // A load sitting in EX whose result the ID instruction reads; $0 never conflicts.
  assign hazard = i_valid & q.valid & q.ctrl.memread & (q.rt != 5'd0) &
                  ((q.rt == rs) | (uses_rt & (q.rt == rt)));
  assign o_stall = ~i_reset & ~i_flush & hazard;

  always_comb begin
    nxt = '0;
    if (!i_flush && !hazard) begin
      nxt.valid   = i_valid;
      nxt.rega    = i_regA;
      nxt.regb    = i_regB;
      nxt.imm     = {{(DATA_WIDTH-16){i_instruction[15]}}, i_instruction[15:0]};
      nxt.rs      = rs;
      nxt.rt      = rt;
      nxt.rd      = i_instruction[15:11];
      nxt.pc      = i_pc;
      nxt.ctrl    = i_valid ? dec : '0;
      nxt.funct   = i_instruction[5:0];
      nxt.illegal = i_valid & ~known;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) q <= '0;
    else         q <= nxt;
  end

  assign o_valid    = q.valid;
  assign o_regA     = q.rega;
  assign o_regB     = q.regb;
  assign o_imm      = q.imm;
  assign o_rs       = q.rs;
  assign o_rt       = q.rt;
  assign o_rd       = q.rd;
  assign o_pc       = q.pc;
  assign o_regdst   = q.ctrl.regdst;
  assign o_alusrc   = q.ctrl.alusrc;
  assign o_memread  = q.ctrl.memread;
  assign o_memwrite = q.ctrl.memwrite;
  assign o_memtoreg = q.ctrl.memtoreg;
  assign o_regwrite = q.ctrl.regwrite;
  assign o_branch   = q.ctrl.branch;
  assign o_aluop    = q.ctrl.aluop;
  assign o_funct    = q.funct;
  assign o_illegal  = q.illegal;

`ifdef STALL_COUNT_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                            o_stall_count <= '0;
    else if (o_stall && o_stall_count != 16'hFFFF) o_stall_count <= o_stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, reset corner case,
// then random instruction streams against a decode/hazard reference model.
module tb_id_ex_stage;
  logic        i_clock = 1'b0, i_reset = 1'b1, i_valid = 1'b0, i_flush = 1'b0;
  logic [31:0] i_instruction = '0, i_pc = '0, i_regA = '0, i_regB = '0;
  logic [4:0]  o_rf_rs, o_rf_rt, o_rs, o_rt, o_rd;
  logic        o_stall, o_valid, o_regdst, o_alusrc, o_memread, o_memwrite;
  logic        o_memtoreg, o_regwrite, o_branch, o_illegal;
  logic [31:0] o_regA, o_regB, o_imm, o_pc;
  logic [1:0]  o_aluop;
  logic [5:0]  o_funct;
`ifdef STALL_COUNT_EN
  logic [15:0] o_stall_count;
`endif

  id_ex_stage #(.DATA_WIDTH(32), .PC_WIDTH(32)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_instruction(i_instruction),
    .i_pc(i_pc), .i_flush(i_flush), .i_regA(i_regA), .i_regB(i_regB),
    .o_rf_rs(o_rf_rs), .o_rf_rt(o_rf_rt), .o_stall(o_stall), .o_valid(o_valid),
    .o_regA(o_regA), .o_regB(o_regB), .o_imm(o_imm), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_pc(o_pc), .o_regdst(o_regdst), .o_alusrc(o_alusrc), .o_memread(o_memread),
    .o_memwrite(o_memwrite), .o_memtoreg(o_memtoreg), .o_regwrite(o_regwrite),
    .o_branch(o_branch), .o_aluop(o_aluop), .o_funct(o_funct), .o_illegal(o_illegal)
`ifdef STALL_COUNT_EN
    , .o_stall_count(o_stall_count)
`endif
  );

  always #5 i_clock = ~i_clock;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ctl_now();
    return {o_regdst, o_alusrc, o_memread, o_memwrite, o_memtoreg, o_regwrite, o_branch, o_aluop};
  endfunction

  // Control words from the opcode table: {regdst,alusrc,memread,memwrite,memtoreg,regwrite,branch,aluop}
  localparam logic [8:0] C_R    = 9'b1_0_0_0_0_1_0_10;
  localparam logic [8:0] C_LW   = 9'b0_1_1_0_1_1_0_00;
  localparam logic [8:0] C_SW   = 9'b0_1_0_1_0_0_0_00;
  localparam logic [8:0] C_BEQ  = 9'b0_0_0_0_0_0_1_01;
  localparam logic [8:0] C_ADDI = 9'b0_1_0_0_0_1_0_00;

  typedef struct {
    logic v; logic [31:0] ins; logic fl;
    logic st; logic ov; logic [31:0] imm; logic [4:0] rt, rd; logic [8:0] ctl; logic ill;
  } vec_t;

  typedef struct packed {
    logic v; logic [31:0] a, b, imm, pc; logic [4:0] rs, rt, rd; logic [5:0] funct;
    logic [8:0] ctl; logic ill;
  } mdl_t;

  function automatic logic [9:0] decode(input logic [5:0] op);
    case (op)
      6'h00: return {1'b0, C_R};
      6'h23: return {1'b0, C_LW};
      6'h2B: return {1'b0, C_SW};
      6'h04: return {1'b0, C_BEQ};
      6'h08: return {1'b0, C_ADDI};
      default: return {1'b1, 9'b0};
    endcase
  endfunction

  // Stall when the load in EX writes a register the ID instruction actually reads.
  function automatic logic load_use(input mdl_t e, input logic v, input logic [31:0] ins);
    logic reads_rt;
    if (!v || !e.v || !e.ctl[6] || e.rt == 5'd0) return 1'b0;
    reads_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) || (ins[31:26] == 6'h04);
    return (e.rt == ins[25:21]) || (reads_rt && e.rt == ins[20:16]);
  endfunction

  vec_t tbl[18];
  mdl_t m;
  int   exp_cnt;

  initial begin
    logic [31:0] row_pc, row_a, ins;
    logic        st, held;
    logic [9:0]  d;
    logic [5:0]  ops[6];

    tbl[0]  = '{1, 32'h2005FFFF, 0, 0, 1, 32'hFFFFFFFF, 5, 31, C_ADDI, 0};
    tbl[1]  = '{1, 32'h8C230004, 0, 0, 1, 32'h4,        3, 0,  C_LW,   0};
    tbl[2]  = '{1, 32'h00622020, 0, 1, 0, 32'h0,        0, 0,  9'h0,   0};
    tbl[3]  = '{1, 32'h00622020, 0, 0, 1, 32'h2020,     2, 4,  C_R,    0};
    tbl[4]  = '{1, 32'h8C230004, 0, 0, 1, 32'h4,        3, 0,  C_LW,   0};
    tbl[5]  = '{1, 32'h00233020, 0, 1, 0, 32'h0,        0, 0,  9'h0,   0};
    tbl[6]  = '{1, 32'h00233020, 0, 0, 1, 32'h3020,     3, 6,  C_R,    0};
    tbl[7]  = '{1, 32'h8C230004, 0, 0, 1, 32'h4,        3, 0,  C_LW,   0};
    tbl[8]  = '{1, 32'h2065FFFF, 0, 1, 0, 32'h0,        0, 0,  9'h0,   0};
    tbl[9]  = '{1, 32'h2065FFFF, 0, 0, 1, 32'hFFFFFFFF, 5, 31, C_ADDI, 0};
    tbl[10] = '{1, 32'h8C230004, 0, 0, 1, 32'h4,        3, 0,  C_LW,   0};
    tbl[11] = '{1, 32'h2003FFFF, 0, 0, 1, 32'hFFFFFFFF, 3, 31, C_ADDI, 0};
    tbl[12] = '{1, 32'h8C230004, 0, 0, 1, 32'h4,        3, 0,  C_LW,   0};
    tbl[13] = '{1, 32'h00622020, 1, 0, 0, 32'h0,        0, 0,  9'h0,   0};
    tbl[14] = '{1, 32'h8C200004, 0, 0, 1, 32'h4,        0, 0,  C_LW,   0};
    tbl[15] = '{1, 32'h00002020, 0, 0, 1, 32'h2020,     0, 4,  C_R,    0};
    tbl[16] = '{1, 32'hFC000000, 0, 0, 1, 32'h0,        0, 0,  9'h0,   1};
    tbl[17] = '{0, 32'h8C230004, 0, 0, 0, 32'h4,        3, 0,  9'h0,   0};

    // Reset state with a real instruction presented
    i_valid = 1'b1; i_instruction = 32'h00622020;
    repeat (2) @(negedge i_clock);
    chk("rst_valid", o_valid, 0);
    chk("rst_ctl", ctl_now(), 0);
    chk("rst_imm", o_imm, 0);
    chk("rst_stall", o_stall, 0);
    i_reset = 1'b0;

    for (int k = 0; k < 18; k++) begin
      ins = tbl[k].ins;
      row_pc = 32'h8 + 32'(4 * k);
      row_a = 32'hA000_0000 + 32'(k);
      i_valid = tbl[k].v; i_instruction = ins; i_flush = tbl[k].fl;
      i_pc = row_pc; i_regA = row_a; i_regB = ~row_a;
      #1;
      chk($sformatf("t%0d_stall", k), o_stall, tbl[k].st);
      chk($sformatf("t%0d_rf", k), {o_rf_rs, o_rf_rt}, {ins[25:21], ins[20:16]});
      @(posedge i_clock); #1;
      chk($sformatf("t%0d_valid", k), o_valid, tbl[k].ov);
      chk($sformatf("t%0d_imm", k), o_imm, tbl[k].imm);
      chk($sformatf("t%0d_rtrd", k), {o_rt, o_rd}, {tbl[k].rt, tbl[k].rd});
      chk($sformatf("t%0d_ctl", k), ctl_now(), tbl[k].ctl);
      chk($sformatf("t%0d_ill", k), o_illegal, tbl[k].ill);
      chk($sformatf("t%0d_pc", k), o_pc, (tbl[k].st || tbl[k].fl) ? 32'h0 : row_pc);
      chk($sformatf("t%0d_rega", k), o_regA, (tbl[k].st || tbl[k].fl) ? 32'h0 : row_a);
      @(negedge i_clock);
    end
`ifdef STALL_COUNT_EN
    chk("stall_count3", o_stall_count, 3);
`endif

    // Reset while a load-use stall is pending
    i_valid = 1'b1; i_flush = 1'b0; i_instruction = 32'h8C230004;
    @(negedge i_clock);
    i_instruction = 32'h00622020; #1;
    chk("pre_rst_stall", o_stall, 1);
    i_reset = 1'b1; #1;
    chk("mid_rst_stall", o_stall, 0);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_ctl", ctl_now(), 0);
    chk("mid_rst_fields", {o_imm, o_rt, o_pc}, 0);
    @(negedge i_clock);
    i_reset = 1'b0;

    // Random streams against the reference model
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
    m = '0; exp_cnt = 0; held = 1'b0; ins = 32'h0;
    for (int n = 0; n < 400; n++) begin
      if (!held)
        ins = {ops[$urandom_range(5)], 5'($urandom_range(3)), 5'($urandom_range(3)), 16'($urandom)};
      i_valid = ($urandom_range(7) != 0);
      i_flush = ($urandom_range(9) == 0);
      i_instruction = ins; i_pc = $urandom; i_regA = $urandom; i_regB = $urandom;
      #1;
      st = load_use(m, i_valid, ins) && !i_flush;
      chk("r_stall", o_stall, st);
      chk("r_rf", {o_rf_rs, o_rf_rt}, {ins[25:21], ins[20:16]});
      d = decode(ins[31:26]);
      if (st || i_flush) m = '0;
      else m = '{i_valid, i_regA, i_regB, {{16{ins[15]}}, ins[15:0]}, i_pc, ins[25:21], ins[20:16],
                 ins[15:11], ins[5:0], i_valid ? d[8:0] : 9'h0, i_valid & d[9]};
      if (st && exp_cnt < 65535) exp_cnt++;
      held = st;
      @(posedge i_clock); #1;
      chk("r_valid", o_valid, m.v);
      chk("r_ctl", ctl_now(), m.ctl);
      chk("r_ill", o_illegal, m.ill);
      chk("r_imm", o_imm, m.imm);
      chk("r_idx", {o_rs, o_rt, o_rd, o_funct}, {m.rs, m.rt, m.rd, m.funct});
      chk("r_ops", {o_regA, o_regB}, {m.a, m.b});
      chk("r_pc", o_pc, m.pc);
      @(negedge i_clock);
    end
`ifdef STALL_COUNT_EN
    chk("r_stall_count", o_stall_count, 16'(exp_cnt));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
